if_stage: RTL and testbench
===========================

# if_stage

Instruction fetch stage of the RV32I pipeline. It owns the fetch PC and drives the synchronous instruction RAM read port. It presents each fetched instruction and its PC to the decode stage as `inst_id` / `pc_id`. It handles pipeline hold (including rollback of the RAM output during stalls), EX-stage jump redirect with wrong-path purge, and pipeline restart.

## Interface
- `RESET_PC`, default 30'h0000_0000: word address [31:2] fetched first after reset or `rst_pipe`.
- `IMEM_AW`, default 12: instruction RAM word-address width (4K words).
- `clk`  in  1: clock; all state updates on rising edge.
- `rst_n`  in  1: reset; asynchronous, active-high (asserted = 1).
- `stall`  in  1: pipeline hold from the hazard/stall controller.
- `stall_ld`  in  1: load-use hold; identical effect to `stall` in this block.
- `rst_pipe`  in  1: synchronous pipeline restart.
- `jmp_condition_ex`  in  1: taken jump/branch/trap redirect from EX.
- `jmp_adr_ex`  in  30: redirect target, word address [31:2].
- `imem_radr`  out  IMEM_AW: instruction RAM read address.
- `imem_rdata`  in  32: instruction RAM data; valid 1 cycle after the address.
- `inst_id`  out  32: instruction to decode.
- `pc_id`  out  30: PC [31:2] of `inst_id`.

## Operation
- `hold = stall | stall_ld`.
- State registers:
  - `pc_if[31:2]`: address being read this cycle.
  - `pc_id[31:2]`.
  - `purge`: 1 bit.
  - `hold_dly`: 1 bit, registered `hold`.
  - `inst_hold[31:0]`.
- `imem_radr = pc_if[IMEM_AW+1:2]`. This is combinational from the register, so no extra latency is added.
- **Next PC**, on an edge with `hold`=0:
  - `jmp_condition_ex`=1: `pc_if <= jmp_adr_ex`.
  - Otherwise: `pc_if <= pc_if + 1`. The increment is 30-bit and wraps from 30'h3FFF_FFFF to 0.
  - In both cases `pc_id <= pc_if`.
- **Hold** (`hold`=1):
  - `pc_if` and `pc_id` are held.
  - `jmp_condition_ex` is ignored; EX holds it stable until the hold releases.
- **Purge**: on an edge with `hold`=0, `purge <= jmp_condition_ex`. `purge` is unchanged while `hold`=1.
- **Output mux**, in priority order:
  1. `purge`=1: `inst_id` = NOP 32'h0000_0013.
  2. Else `hold_dly`=1: `inst_id` = `inst_hold`.
  3. Else: `inst_id` = `imem_rdata`.
- **Rollback capture**: `inst_hold <= inst_id` on the edge where `hold`=1 and `hold_dly`=0, i.e. the first cycle of a hold. This is required because the RAM keeps re-reading `pc_if` during the hold, so `imem_rdata` no longer matches `pc_id`.
- **`rst_pipe`**, synchronous, overrides `hold` and redirect, same effect as reset:
  - `pc_if <= RESET_PC`, `pc_id <= 0`, `purge <= 1`, `hold_dly <= 0`, `inst_hold <= 32'h13`.
- **Reset values** (`rst_n`=1), asynchronous:
  - `pc_if = RESET_PC`, so `imem_radr = RESET_PC[IMEM_AW-1:0]`.
  - `pc_id = 0`, `purge = 1`, `hold_dly = 0`, `inst_hold = 32'h13`.
  - Therefore `inst_id = 32'h0000_0013`.
- The first instruction after reset or `rst_pipe` appears one non-held cycle later.

## Timing
- Fetch latency is 1 cycle. If `pc_if`=A in cycle n with no hold, then in cycle n+1: `pc_id`=A, `inst_id`=mem[A].
- Sustained throughput is 1 instruction per cycle without hold.
- **Redirect** asserted in cycle n (`pc_if`=B, target T):
  - Cycle n+1: `pc_if`=T, `pc_id`=B, `inst_id`=NOP.
  - Cycle n+2: `pc_id`=T, `inst_id`=mem[T].
- Back-to-back redirects: each one inserts exactly one NOP and the latest target wins.
- **Hold** asserted cycles h..r-1, released in cycle r:
  - `inst_id` and `pc_id` are stable over cycles h..r, with no glitch at h+1 or at r.
  - Cycle r+1 carries the next sequential instruction.
- A 1-cycle hold still captures into `inst_hold` and serves it for exactly 1 cycle.
- Redirect coincident with hold is not taken until the first non-held edge.

## Test plan
- **Reset and sequential fetch**: RAM[0..3]=32'h00100093, 32'h00200113, 32'h00300193, 32'h00400213, `RESET_PC`=0. Release reset.
  - Cycle 0: `inst_id`=32'h13.
  - Cycles 1..4: `pc_id`=0,1,2,3 and the four words in order.
- **Jump purge**: redirect in the cycle `pc_if`=2 with `jmp_adr_ex`=30'h10.
  - Next cycle: `inst_id`=32'h13, `pc_id`=2.
  - Following cycle: `pc_id`=30'h10, `inst_id`=RAM[16].
- **Stall rollback**: assert `stall` for 3 cycles while `pc_id`=1.
  - `inst_id` stays 32'h00200113 and `pc_id` stays 1 throughout, including the release cycle.
  - Then `pc_id`=2, `inst_id`=32'h00300193.
- **Stall plus redirect**: assert `jmp_condition_ex`=1 (target 30'h20) during a 2-cycle `stall_ld`.
  - `pc_if` is unchanged during the hold.
  - After release: one NOP, then `pc_id`=30'h20.
- **`rst_pipe` mid-stream**: pulse `rst_pipe` with `stall`=1 and `pc_if`=30'h21.
  - Next cycle: `pc_if`=`RESET_PC`, `inst_id`=32'h13, `pc_id`=0.
- **Async reset and wrap**:
  - Assert `rst_n` mid-cycle: outputs go to reset values immediately, with no clock edge.
  - Separately, redirect to 30'h3FFF_FFFF: next `pc_if`=0.

Source files
------------

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage
//
// Instruction fetch stage of the RV32I pipeline. Owns the fetch PC, drives
// the synchronous instruction RAM read port and presents each fetched
// instruction together with its PC to the decode stage.
//
// Parameters
//   RESET_PC  word address [31:2] fetched first after reset / rst_pipe
//   IMEM_AW   instruction RAM word-address width
//
// Ports
//   clk               clock, all state updates on the rising edge
//   rst_n             asynchronous reset, active-high (asserted = 1)
//   stall             pipeline hold from the hazard/stall controller
//   stall_ld          load-use hold, same effect as stall here
//   rst_pipe          synchronous pipeline restart
//   jmp_condition_ex  taken jump/branch/trap redirect from EX
//   jmp_adr_ex        redirect target, word address [31:2]
//   imem_radr         instruction RAM read address
//   imem_rdata        instruction RAM data, valid one cycle after address
//   inst_id           instruction handed to decode
//   pc_id             PC [31:2] of inst_id
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [29:0] RESET_PC = 30'h0000_0000,
  parameter int          IMEM_AW  = 12
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               stall_ld,
  input  logic               rst_pipe,
  input  logic               jmp_condition_ex,
  input  logic [29:0]        jmp_adr_ex,
  output logic [IMEM_AW-1:0] imem_radr,
  input  logic [31:0]        imem_rdata,
  output logic [31:0]        inst_id,
  output logic [29:0]        pc_id
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        hold;
  logic [29:0] pc_if;
  logic        purge;
  logic        hold_dly;
  logic [31:0] inst_hold;

  assign hold = stall | stall_ld;

  // The RAM address comes straight from the fetch PC register so the read
  // starts in the same cycle the PC is valid.
  assign imem_radr = pc_if[IMEM_AW-1:0];

  // Fetch state. While held, the PC pair and purge flag freeze; the RAM keeps
  // re-reading pc_if, so on the first held cycle the instruction currently
  // shown to decode is captured into inst_hold and replayed until release.
  // A taken redirect loads the target and arms purge so the wrong-path word
  // that arrives on the next cycle is replaced by a NOP.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      pc_if     <= RESET_PC;
      pc_id     <= 30'd0;
      purge     <= 1'b1;
      hold_dly  <= 1'b0;
      inst_hold <= NOP;
    end else if (rst_pipe) begin
      pc_if     <= RESET_PC;
      pc_id     <= 30'd0;
      purge     <= 1'b1;
      hold_dly  <= 1'b0;
      inst_hold <= NOP;
    end else begin
      hold_dly <= hold;
      if (!hold) begin
        pc_if <= jmp_condition_ex ? jmp_adr_ex : pc_if + 30'd1;
        pc_id <= pc_if;
        purge <= jmp_condition_ex;
      end
      if (hold && !hold_dly) begin
        inst_hold <= inst_id;
      end
    end
  end

  // Output selection: purge beats the rollback copy, which beats live RAM
  // data. hold_dly stays high through the release cycle so the replayed
  // word is shown until fresh data for the next PC arrives.
  always_comb begin
    inst_id = imem_rdata;
    if (purge) begin
      inst_id = NOP;
    end else if (hold_dly) begin
      inst_id = inst_hold;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage
//
// Directed bench for if_stage. A synchronous RAM model feeds imem_rdata.
// Inputs change 1 time unit after a rising edge and outputs are sampled in
// the same window, so each "tick" advances exactly one pipeline cycle.
// ---------------------------------------------------------------------------
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        stall_ld;
  logic        rst_pipe;
  logic        jmp_condition_ex;
  logic [29:0] jmp_adr_ex;
  logic [11:0] imem_radr;
  logic [31:0] imem_rdata;
  logic [31:0] inst_id;
  logic [29:0] pc_id;

  logic [31:0] mem [0:4095];

  int total;
  int bad;

  if_stage #(
    .RESET_PC (30'h0000_0000),
    .IMEM_AW  (12)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .stall            (stall),
    .stall_ld         (stall_ld),
    .rst_pipe         (rst_pipe),
    .jmp_condition_ex (jmp_condition_ex),
    .jmp_adr_ex       (jmp_adr_ex),
    .imem_radr        (imem_radr),
    .imem_rdata       (imem_rdata),
    .inst_id          (inst_id),
    .pc_id            (pc_id)
  );

  // 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Synchronous instruction RAM, one cycle read latency
  always @(posedge clk) begin
    imem_rdata <= mem[imem_radr];
  end

  // Safety net so the run always terminates
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Restart the pipeline; returns in the cycle where pc_if = RESET_PC
  task automatic restart();
    rst_pipe = 1'b1;
    tick();
    rst_pipe = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    tick();
    tick();
    total++; if (inst_id !== 32'h13) begin bad++; $display("[TB] FAIL reset_inst got=%h exp=%h", inst_id, 32'h13); end
    total++; if (pc_id !== 30'd0) begin bad++; $display("[TB] FAIL reset_pc_id got=%h exp=%h", pc_id, 30'd0); end
    total++; if (imem_radr !== 12'd0) begin bad++; $display("[TB] FAIL reset_radr got=%h exp=%h", imem_radr, 12'd0); end
    rst_n = 1'b0;
    // cycle 0 after release still shows NOP
    total++; if (inst_id !== 32'h13) begin bad++; $display("[TB] FAIL cycle0_inst got=%h exp=%h", inst_id, 32'h13); end
    for (int i = 0; i < 4; i++) begin
      tick();
      total++; if (pc_id !== 30'(i)) begin bad++; $display("[TB] FAIL seq_pc_id[%0d] got=%h exp=%h", i, pc_id, 30'(i)); end
      total++; if (inst_id !== mem[i]) begin bad++; $display("[TB] FAIL seq_inst[%0d] got=%h exp=%h", i, inst_id, mem[i]); end
    end
  endtask

  task automatic test_jump();
    restart();
    tick();
    tick();
    // pc_if = 2 now
    total++; if (imem_radr !== 12'd2) begin bad++; $display("[TB] FAIL jump_pre_radr got=%h exp=%h", imem_radr, 12'd2); end
    jmp_condition_ex = 1'b1;
    jmp_adr_ex       = 30'h10;
    tick();
    jmp_condition_ex = 1'b0;
    total++; if (inst_id !== 32'h13) begin bad++; $display("[TB] FAIL jump_nop got=%h exp=%h", inst_id, 32'h13); end
    total++; if (pc_id !== 30'd2) begin bad++; $display("[TB] FAIL jump_pc_id_b got=%h exp=%h", pc_id, 30'd2); end
    total++; if (imem_radr !== 12'h10) begin bad++; $display("[TB] FAIL jump_radr got=%h exp=%h", imem_radr, 12'h10); end
    tick();
    total++; if (pc_id !== 30'h10) begin bad++; $display("[TB] FAIL jump_pc_id_t got=%h exp=%h", pc_id, 30'h10); end
    total++; if (inst_id !== mem[16]) begin bad++; $display("[TB] FAIL jump_inst_t got=%h exp=%h", inst_id, mem[16]); end
  endtask

  task automatic test_back_to_back();
    restart();
    tick();
    jmp_condition_ex = 1'b1;
    jmp_adr_ex       = 30'h40;
    tick();
    total++; if (inst_id !== 32'h13) begin bad++; $display("[TB] FAIL b2b_nop1 got=%h exp=%h", inst_id, 32'h13); end
    total++; if (pc_id !== 30'd1) begin bad++; $display("[TB] FAIL b2b_pc_id1 got=%h exp=%h", pc_id, 30'd1); end
    jmp_adr_ex = 30'h50;
    tick();
    jmp_condition_ex = 1'b0;
    total++; if (inst_id !== 32'h13) begin bad++; $display("[TB] FAIL b2b_nop2 got=%h exp=%h", inst_id, 32'h13); end
    total++; if (pc_id !== 30'h40) begin bad++; $display("[TB] FAIL b2b_pc_id2 got=%h exp=%h", pc_id, 30'h40); end
    tick();
    total++; if (pc_id !== 30'h50) begin bad++; $display("[TB] FAIL b2b_pc_id3 got=%h exp=%h", pc_id, 30'h50); end
    total++; if (inst_id !== mem[12'h50]) begin bad++; $display("[TB] FAIL b2b_inst3 got=%h exp=%h", inst_id, mem[12'h50]); end
  endtask

  task automatic test_stall_rollback();
    restart();
    tick();
    tick();
    // pc_id = 1, inst = mem[1]; hold for three cycles
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      total++; if (inst_id !== 32'h00200113) begin bad++; $display("[TB] FAIL stall_inst[%0d] got=%h exp=%h", k, inst_id, 32'h00200113); end
      total++; if (pc_id !== 30'd1) begin bad++; $display("[TB] FAIL stall_pc_id[%0d] got=%h exp=%h", k, pc_id, 30'd1); end
      total++; if (imem_radr !== 12'd2) begin bad++; $display("[TB] FAIL stall_radr[%0d] got=%h exp=%h", k, imem_radr, 12'd2); end
      tick();
    end
    stall = 1'b0;
    // release cycle
    total++; if (inst_id !== 32'h00200113) begin bad++; $display("[TB] FAIL stall_rel_inst got=%h exp=%h", inst_id, 32'h00200113); end
    total++; if (pc_id !== 30'd1) begin bad++; $display("[TB] FAIL stall_rel_pc_id got=%h exp=%h", pc_id, 30'd1); end
    tick();
    total++; if (pc_id !== 30'd2) begin bad++; $display("[TB] FAIL stall_after_pc_id got=%h exp=%h", pc_id, 30'd2); end
    total++; if (inst_id !== 32'h00300193) begin bad++; $display("[TB] FAIL stall_after_inst got=%h exp=%h", inst_id, 32'h00300193); end
  endtask

  task automatic test_one_cycle_hold();
    restart();
    tick();
    tick();
    stall = 1'b1;
    total++; if (inst_id !== mem[1]) begin bad++; $display("[TB] FAIL hold1_h_inst got=%h exp=%h", inst_id, mem[1]); end
    tick();
    stall = 1'b0;
    total++; if (inst_id !== mem[1]) begin bad++; $display("[TB] FAIL hold1_r_inst got=%h exp=%h", inst_id, mem[1]); end
    total++; if (pc_id !== 30'd1) begin bad++; $display("[TB] FAIL hold1_r_pc_id got=%h exp=%h", pc_id, 30'd1); end
    tick();
    total++; if (inst_id !== mem[2]) begin bad++; $display("[TB] FAIL hold1_n1_inst got=%h exp=%h", inst_id, mem[2]); end
    tick();
    total++; if (inst_id !== mem[3]) begin bad++; $display("[TB] FAIL hold1_n2_inst got=%h exp=%h", inst_id, mem[3]); end
    total++; if (pc_id !== 30'd3) begin bad++; $display("[TB] FAIL hold1_n2_pc_id got=%h exp=%h", pc_id, 30'd3); end
  endtask

  task automatic test_stall_jump();
    restart();
    tick();
    tick();
    // pc_if = 2, pc_id = 1; two-cycle load-use hold with a pending redirect
    stall_ld         = 1'b1;
    jmp_condition_ex = 1'b1;
    jmp_adr_ex       = 30'h20;
    tick();
    total++; if (imem_radr !== 12'd2) begin bad++; $display("[TB] FAIL sj_h1_radr got=%h exp=%h", imem_radr, 12'd2); end
    total++; if (pc_id !== 30'd1) begin bad++; $display("[TB] FAIL sj_h1_pc_id got=%h exp=%h", pc_id, 30'd1); end
    tick();
    stall_ld = 1'b0;
    total++; if (imem_radr !== 12'd2) begin bad++; $display("[TB] FAIL sj_rel_radr got=%h exp=%h", imem_radr, 12'd2); end
    total++; if (inst_id !== mem[1]) begin bad++; $display("[TB] FAIL sj_rel_inst got=%h exp=%h", inst_id, mem[1]); end
    tick();
    jmp_condition_ex = 1'b0;
    total++; if (inst_id !== 32'h13) begin bad++; $display("[TB] FAIL sj_nop got=%h exp=%h", inst_id, 32'h13); end
    total++; if (pc_id !== 30'd2) begin bad++; $display("[TB] FAIL sj_nop_pc_id got=%h exp=%h", pc_id, 30'd2); end
    tick();
    total++; if (pc_id !== 30'h20) begin bad++; $display("[TB] FAIL sj_target_pc_id got=%h exp=%h", pc_id, 30'h20); end
    total++; if (inst_id !== mem[32]) begin bad++; $display("[TB] FAIL sj_target_inst got=%h exp=%h", inst_id, mem[32]); end
  endtask

  task automatic test_rst_pipe();
    // pc_if = 0x21 here, left by the previous scenario
    total++; if (imem_radr !== 12'h21) begin bad++; $display("[TB] FAIL rp_pre_radr got=%h exp=%h", imem_radr, 12'h21); end
    stall    = 1'b1;
    rst_pipe = 1'b1;
    tick();
    stall    = 1'b0;
    rst_pipe = 1'b0;
    total++; if (imem_radr !== 12'd0) begin bad++; $display("[TB] FAIL rp_radr got=%h exp=%h", imem_radr, 12'd0); end
    total++; if (inst_id !== 32'h13) begin bad++; $display("[TB] FAIL rp_inst got=%h exp=%h", inst_id, 32'h13); end
    total++; if (pc_id !== 30'd0) begin bad++; $display("[TB] FAIL rp_pc_id got=%h exp=%h", pc_id, 30'd0); end
  endtask

  task automatic test_async_reset();
    tick();
    tick();
    total++; if (inst_id !== mem[1]) begin bad++; $display("[TB] FAIL ar_pre_inst got=%h exp=%h", inst_id, mem[1]); end
    #2;
    rst_n = 1'b1;
    #1;
    total++; if (inst_id !== 32'h13) begin bad++; $display("[TB] FAIL ar_inst got=%h exp=%h", inst_id, 32'h13); end
    total++; if (pc_id !== 30'd0) begin bad++; $display("[TB] FAIL ar_pc_id got=%h exp=%h", pc_id, 30'd0); end
    total++; if (imem_radr !== 12'd0) begin bad++; $display("[TB] FAIL ar_radr got=%h exp=%h", imem_radr, 12'd0); end
    tick();
    rst_n = 1'b0;
  endtask

  task automatic test_wrap();
    jmp_condition_ex = 1'b1;
    jmp_adr_ex       = 30'h3FFF_FFFF;
    tick();
    jmp_condition_ex = 1'b0;
    total++; if (imem_radr !== 12'hFFF) begin bad++; $display("[TB] FAIL wrap_radr_top got=%h exp=%h", imem_radr, 12'hFFF); end
    total++; if (inst_id !== 32'h13) begin bad++; $display("[TB] FAIL wrap_nop got=%h exp=%h", inst_id, 32'h13); end
    tick();
    total++; if (imem_radr !== 12'd0) begin bad++; $display("[TB] FAIL wrap_radr_zero got=%h exp=%h", imem_radr, 12'd0); end
    total++; if (pc_id !== 30'h3FFF_FFFF) begin bad++; $display("[TB] FAIL wrap_pc_id_top got=%h exp=%h", pc_id, 30'h3FFF_FFFF); end
    total++; if (inst_id !== mem[4095]) begin bad++; $display("[TB] FAIL wrap_inst_top got=%h exp=%h", inst_id, mem[4095]); end
    tick();
    total++; if (pc_id !== 30'd0) begin bad++; $display("[TB] FAIL wrap_pc_id_zero got=%h exp=%h", pc_id, 30'd0); end
    total++; if (inst_id !== mem[0]) begin bad++; $display("[TB] FAIL wrap_inst_zero got=%h exp=%h", inst_id, mem[0]); end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 4096; i++) begin
      mem[i] = 32'hA000_0000 | 32'(i);
    end
    mem[0] = 32'h00100093;
    mem[1] = 32'h00200113;
    mem[2] = 32'h00300193;
    mem[3] = 32'h00400213;

    rst_n            = 1'b1;
    stall            = 1'b0;
    stall_ld         = 1'b0;
    rst_pipe         = 1'b0;
    jmp_condition_ex = 1'b0;
    jmp_adr_ex       = 30'd0;

    test_reset();
    test_jump();
    test_back_to_back();
    test_stall_rollback();
    test_one_cycle_hold();
    test_stall_jump();
    test_rst_pipe();
    test_async_reset();
    test_wrap();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
